// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file.
// Picks the writeback value, commits it to the GPRs, and serves two bypassed
// read ports. It also keeps a retire counter and a one-cycle-delayed commit trace.
module wb_regfile #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned CNT_W  = 64,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   wb_mem_out,
    input  logic [XLEN-1:0]   wb_alu_out,
    input  logic [AW-1:0]     wb_rd,
    input  logic              wb_mem2reg,
    input  logic              wb_reg_write_ena,
    input  logic [AW-1:0]     rs1_addr,
    input  logic [AW-1:0]     rs2_addr,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic [XLEN-1:0]   wb_data,
    output logic              trace_valid,
    output logic [AW-1:0]     trace_rd,
    output logic [XLEN-1:0]   trace_data,
    output logic [CNT_W-1:0]  retire_count
);

    localparam int unsigned NREG = 1 << AW;

    logic [XLEN-1:0] regs [NREG];
    logic            commit;

    // Writeback select, and the qualified write strobe. Reset suppresses both the write and the bypass.
    always_comb begin
        wb_data = wb_mem2reg ? wb_mem_out : wb_alu_out;
        commit  = !reset && wb_reg_write_ena && (wb_rd != '0);
    end

    // GPR array: cleared on reset, written on commit. The write to x0 is already filtered out in commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[AW'(i)] <= '0;
            end
        end else if (commit) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Read port 1: x0 is hardwired to zero, then the same-cycle bypass, then the array.
    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if ((BYPASS != 0) && commit && (rs1_addr == wb_rd)) begin
            rs1_data = wb_data;
        end
    end

    // Read port 2: same priority rules as port 1, resolved independently.
    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if ((BYPASS != 0) && commit && (rs2_addr == wb_rd)) begin
            rs2_data = wb_data;
        end
    end

    // Commit trace: valid pulses for one cycle per commit. rd and data hold between commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_rd    <= '0;
            trace_data  <= '0;
        end else begin
            trace_valid <= commit;
            if (commit) begin
                trace_rd   <= wb_rd;
                trace_data <= wb_data;
            end
        end
    end

    // Retire counter: counts every enabled writeback, including discarded x0 writes, and wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_count <= '0;
        end else if (wb_reg_write_ena) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile. It drives two instances from the same inputs: the default
// configuration, and a variant with BYPASS=0 and CNT_W=4. Both are compared against
// a behavioural model, plus directed table vectors.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_mem_out, wb_alu_out;
    logic [4:0]  wb_rd;
    logic        wb_mem2reg, wb_reg_write_ena;
    logic [4:0]  rs1_addr, rs2_addr;

    logic [31:0] rs1_data, rs2_data, wb_data, trace_data;
    logic        trace_valid;
    logic [4:0]  trace_rd;
    logic [63:0] retire_count;

    logic [31:0] nb_rs1_data, nb_rs2_data, nb_wb_data, nb_trace_data;
    logic        nb_trace_valid;
    logic [4:0]  nb_trace_rd;
    logic [3:0]  nb_retire_count;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .reset(reset), .wb_mem_out(wb_mem_out), .wb_alu_out(wb_alu_out),
        .wb_rd(wb_rd), .wb_mem2reg(wb_mem2reg), .wb_reg_write_ena(wb_reg_write_ena),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_data(wb_data), .trace_valid(trace_valid), .trace_rd(trace_rd),
        .trace_data(trace_data), .retire_count(retire_count)
    );

    wb_regfile #(.CNT_W(4), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .wb_mem_out(wb_mem_out), .wb_alu_out(wb_alu_out),
        .wb_rd(wb_rd), .wb_mem2reg(wb_mem2reg), .wb_reg_write_ena(wb_reg_write_ena),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
        .wb_data(nb_wb_data), .trace_valid(nb_trace_valid), .trace_rd(nb_trace_rd),
        .trace_data(nb_trace_data), .retire_count(nb_retire_count)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model of the architectural state
    logic [31:0] mregs [32];
    logic [63:0] mcnt;
    logic        mtv;
    logic [4:0]  mtrd;
    logic [31:0] mtdata;
    bit          mvalid = 1'b0;

    // Combinational outputs sampled in the most recent cycle
    logic [31:0] s_rs1, s_rs2, s_wb, s_nb_rs1, s_nb_rs2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit cm,
                                               input logic [31:0] wbd, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && cm && a == wb_rd) return wbd;
        return mregs[a];
    endfunction

    // One clock cycle: check the combinational outputs, step the model, then check the registered outputs.
    task automatic cycle();
        logic [31:0] wbd;
        bit          cm;
        @(negedge clk);
        wbd = wb_mem2reg ? wb_mem_out : wb_alu_out;
        cm  = !reset && wb_reg_write_ena && (wb_rd != 5'd0);
        s_rs1 = rs1_data; s_rs2 = rs2_data; s_wb = wb_data;
        s_nb_rs1 = nb_rs1_data; s_nb_rs2 = nb_rs2_data;
        if (mvalid) begin
            check("wb_data", 64'(wb_data), 64'(wbd));
            check("nb_wb_data", 64'(nb_wb_data), 64'(wbd));
            check("rs1_data", 64'(rs1_data), 64'(model_read(rs1_addr, cm, wbd, 1'b1)));
            check("rs2_data", 64'(rs2_data), 64'(model_read(rs2_addr, cm, wbd, 1'b1)));
            check("nb_rs1_data", 64'(nb_rs1_data), 64'(model_read(rs1_addr, cm, wbd, 1'b0)));
            check("nb_rs2_data", 64'(nb_rs2_data), 64'(model_read(rs2_addr, cm, wbd, 1'b0)));
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            mcnt = 64'd0; mtv = 1'b0; mtrd = 5'd0; mtdata = 32'd0;
            mvalid = 1'b1;
        end else begin
            if (wb_reg_write_ena) mcnt = mcnt + 64'd1;
            mtv = cm;
            if (cm) begin
                mregs[wb_rd] = wbd;
                mtrd = wb_rd;
                mtdata = wbd;
            end
        end
        #1;
        if (mvalid) begin
            check("trace_valid", 64'(trace_valid), 64'(mtv));
            check("trace_rd", 64'(trace_rd), 64'(mtrd));
            check("trace_data", 64'(trace_data), 64'(mtdata));
            check("retire_count", retire_count, mcnt);
            check("nb_retire_count", 64'(nb_retire_count), 64'(mcnt % 64'd16));
            check("nb_trace_data", 64'(nb_trace_data), 64'(mtdata));
        end
    endtask

    task automatic drive(input logic rst, input logic ena, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] a1, input logic [4:0] a2);
        reset = rst; wb_reg_write_ena = ena; wb_mem2reg = m2r; wb_rd = rd;
        wb_mem_out = mem; wb_alu_out = alu; rs1_addr = a1; rs2_addr = a2;
    endtask

    typedef struct {
        logic        ena;
        logic        m2r;
        logic [4:0]  rd;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_wb;
        logic [31:0] e_nb_rs2;
        logic        e_tv;
        logic [4:0]  e_trd;
        logic [31:0] e_tdata;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t vt [8];

    initial begin
        // ena m2r rd mem alu a1 a2 | rs1 rs2 wb nb_rs2 | tv trd tdata cnt
        vt[0] = '{1'b1, 1'b0, 5'd3, 32'h0, 32'h1234_5678, 5'd3, 5'd0,
                  32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 5'd3, 32'h1234_5678, 64'd1};
        vt[1] = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3,
                  32'h1234_5678, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0, 5'd3, 32'h1234_5678, 64'd1};
        vt[2] = '{1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 32'h1, 5'd7, 5'd7,
                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 1'b1, 5'd7, 32'hDEAD_BEEF, 64'd2};
        vt[3] = '{1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd7,
                  32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 5'd7, 32'hDEAD_BEEF, 64'd3};
        vt[4] = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0,
                  32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd7, 32'hDEAD_BEEF, 64'd3};
        vt[5] = '{1'b1, 1'b0, 5'd4, 32'h0, 32'h1, 5'd3, 5'd4,
                  32'h1234_5678, 32'h1, 32'h1, 32'h0, 1'b1, 5'd4, 32'h1, 64'd4};
        vt[6] = '{1'b1, 1'b0, 5'd4, 32'h0, 32'h2, 5'd7, 5'd4,
                  32'hDEAD_BEEF, 32'h2, 32'h2, 32'h1, 1'b1, 5'd4, 32'h2, 64'd5};
        vt[7] = '{1'b0, 1'b0, 5'd4, 32'h0, 32'h9, 5'd4, 5'd4,
                  32'h2, 32'h2, 32'h9, 32'h2, 1'b0, 5'd4, 32'h2, 64'd5};

        // Reset held for two cycles with a write pending to x5
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h0, 32'h55, 5'd5, 5'd5);
        cycle();
        cycle();
        check("reset_count", retire_count, 64'd0);
        check("reset_trace_valid", 64'(trace_valid), 64'd0);
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(a), 5'(31 - a));
            cycle();
            check("reset_read_rs1", 64'(s_rs1), 64'd0);
            check("reset_read_rs2", 64'(s_rs2), 64'd0);
        end

        // Directed table
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, vt[i].ena, vt[i].m2r, vt[i].rd, vt[i].mem, vt[i].alu, vt[i].a1, vt[i].a2);
            cycle();
            check("tbl_rs1", 64'(s_rs1), 64'(vt[i].e_rs1));
            check("tbl_rs2", 64'(s_rs2), 64'(vt[i].e_rs2));
            check("tbl_wb", 64'(s_wb), 64'(vt[i].e_wb));
            check("tbl_nb_rs2", 64'(s_nb_rs2), 64'(vt[i].e_nb_rs2));
            check("tbl_trace_valid", 64'(trace_valid), 64'(vt[i].e_tv));
            check("tbl_trace_rd", 64'(trace_rd), 64'(vt[i].e_trd));
            check("tbl_trace_data", 64'(trace_data), 64'(vt[i].e_tdata));
            check("tbl_count", retire_count, vt[i].e_cnt);
        end

        // Counter wrap: 17 enabled cycles wrap the 4-bit counter to 1
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        cycle();
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b1, 1'b0, 5'd0, $urandom, $urandom, 5'd9, 5'd0);
            cycle();
        end
        check("wrap_nb_count", 64'(nb_retire_count), 64'd1);
        check("wrap_count", retire_count, 64'd17);

        // A write presented together with reset is dropped, uncounted, and not bypassed
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h0, 32'hABCD, 5'd9, 5'd9);
        cycle();
        check("rst_write_bypass", 64'(s_rs1), 64'd0);
        check("rst_write_count", retire_count, 64'd0);
        check("rst_write_nb_count", 64'(nb_retire_count), 64'd0);
        check("rst_write_trace", 64'(trace_valid), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);
        cycle();
        check("rst_write_dropped", 64'(s_rs1), 64'd0);

        // Randomized traffic against the model, with occasional mid-stream resets
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd;
            rd = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), rd, $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
